mac_frame_accumulator: RTL and testbench
========================================

# mac_frame_accumulator

Downstream consumer of the multiply-add pipeline stage (`data_out = A*B + C`, 2*SIZE bits wide, registered).
- Accepts one product-sum per valid cycle and accumulates FRAME_LEN consecutive samples into a frame sum.
- Presents each frame sum on a valid/ready output register.
- The upstream pipeline is free-running and cannot stall. A frame that completes while the previous result is unconsumed overwrites it and raises a sticky overrun flag.

## Interface
- SIZE, 8, operand width of the upstream stage; the sample width is 2*SIZE.
- FRAME_LEN, 4, samples per frame; legal range 2..256.
- SUMW, 2*SIZE+$clog2(FRAME_LEN), derived local parameter; the frame sum width.

- clk  in  1  single clock; all logic updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  data_in carries a sample this cycle.
- data_in  in  2*SIZE  unsigned sample from the upstream stage.
- out_valid  out  1  sum_out/max_out hold an unconsumed frame result.
- out_ready  in  1  consumer accepts the result on this edge when out_valid=1.
- sum_out  out  SUMW  unsigned frame sum.
- max_out  out  2*SIZE  largest sample in the frame (see Configuration).
- sample_cnt  out  $clog2(FRAME_LEN)  samples accumulated in the current partial frame.
- overrun  out  1  sticky: set when an unconsumed result was overwritten.

## Operation
- State machine: IDLE (sample_cnt=0, acc=0), ACCUM (0<sample_cnt<FRAME_LEN).
  - IDLE -> ACCUM on the first accepted sample.
  - ACCUM -> IDLE on the FRAME_LEN-th sample, which is the frame-complete event.
  - in_valid=0 holds the current state and the accumulator.
- Accumulation:
  - acc is SUMW bits, unsigned, zero-extended adds.
  - acc cannot overflow: FRAME_LEN*(2^(2*SIZE)-1) < 2^SUMW.
- Frame-complete edge:
  - sum_out <= acc + data_in.
  - out_valid <= 1.
  - acc <= 0 and sample_cnt <= 0.
- Output handshake:
  - A transfer occurs on an edge where out_valid=1 and out_ready=1. It clears out_valid unless a frame completes on the same edge.
  - While out_valid=1 and no transfer occurs, sum_out and max_out are stable.
  - out_ready is ignored while out_valid=0.
- Simultaneous transfer and frame-complete: the new result is loaded, out_valid stays 1, and overrun is not set.
- Frame-complete with out_valid=1 and out_ready=0: the new result overwrites the old one, out_valid stays 1, and overrun <= 1.
- overrun is cleared only by reset.
- Reset: every register returns to its reset value on the next edge, including mid-frame, and any partial frame is discarded. Samples presented during reset are ignored.

## Timing
- Reset values: out_valid=0, sum_out=0, max_out=0, sample_cnt=0, overrun=0, internal acc=0, state IDLE.
- Latency: the frame result is visible one cycle after the edge that samples the last in_valid, i.e. registered on that edge.
- Throughput: one sample per clock. Back-to-back frames with no gap are supported; the first sample of the next frame may arrive on the cycle right after frame-complete.
- sample_cnt updates on the same edge that accepts a sample. It wraps FRAME_LEN-1 -> 0 on frame-complete.
- No combinational path from any input to any output.

## Configuration
- Macro `MAC_ACC_MAX_EN`.
- Defined:
  - A 2*SIZE running-maximum register tracks the largest sample of the current frame.
  - It resets to 0 at frame start, is compared unsigned, and on a tie keeps the existing value.
  - max_out loads together with sum_out on frame-complete.
- Undefined:
  - No maximum logic is built.
  - max_out is constant 0.
  - All other behaviour is identical.

## Test plan
- SIZE=8, FRAME_LEN=4, out_ready=1: samples 10, 20, 30, 40 on consecutive cycles -> sum_out=100 and out_valid=1 for exactly one cycle, one cycle after 40. With the macro defined, max_out=40.
- Four samples of 0xFFFF -> sum_out=0x3FFFC (18 bits), no truncation.
- in_valid gaps: samples 1, (idle 3 cycles), 2, 3, (idle), 4 -> sample_cnt steps 1, 2, 3, 0; sum_out=10.
- out_ready=0: two full frames, {1,1,1,1} then {2,2,2,2} -> after the second, sum_out=8, out_valid=1, overrun=1. out_ready=1 one cycle later -> out_valid=0 and overrun stays 1.
- Frame-complete on the same edge as out_ready=1 -> new sum loaded, out_valid stays 1, overrun=0.
- reset asserted after 2 samples (5, 6), then 4 samples of 1 -> sum_out=4 (partial frame discarded); all outputs 0 during reset.

Source files
------------

// File: rtl/mac_frame_accumulator.sv
// Accumulates FRAME_LEN upstream product-sums into a frame sum held in a valid/ready output register.
// Define MAC_ACC_MAX_EN to also track the largest sample of each frame on max_out.
module mac_frame_accumulator #(
    parameter  int SIZE      = 8,
    parameter  int FRAME_LEN = 4,
    localparam int DW        = 2 * SIZE,
    localparam int CNTW      = $clog2(FRAME_LEN),
    localparam int SUMW      = 2 * SIZE + $clog2(FRAME_LEN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [DW-1:0]   data_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SUMW-1:0] sum_out,
    output logic [DW-1:0]   max_out,
    output logic [CNTW-1:0] sample_cnt,
    output logic            overrun
);

    typedef enum logic {
        IDLE,
        ACCUM
    } state_t;

    localparam logic [CNTW-1:0] LAST_CNT = CNTW'(FRAME_LEN - 1);

    state_t            r_state;
    state_t            w_nextState;
    logic [CNTW-1:0]   r_cnt;
    logic [CNTW-1:0]   w_cntNext;
    logic [SUMW-1:0]   r_acc;
    logic [SUMW-1:0]   w_accNext;
    logic [SUMW-1:0]   w_sum;
    logic              w_frameDone;
    logic              r_outValid;
    logic [SUMW-1:0]   r_sumOut;
    logic              r_overrun;

    assign w_sum = r_acc + SUMW'(data_in);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_cntNext;
            r_acc   <= w_accNext;
        end
    end

    // The last sample of a frame is folded directly into sum_out, so the accumulator restarts at zero.
    always_comb begin
        w_nextState = r_state;
        w_cntNext   = r_cnt;
        w_accNext   = r_acc;
        w_frameDone = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_nextState = ACCUM;
                    w_cntNext   = CNTW'(1);
                    w_accNext   = w_sum;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    if (r_cnt == LAST_CNT) begin
                        w_frameDone = 1'b1;
                        w_nextState = IDLE;
                        w_cntNext   = '0;
                        w_accNext   = '0;
                    end else begin
                        w_cntNext = r_cnt + CNTW'(1);
                        w_accNext = w_sum;
                    end
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // The upstream cannot stall, so a new result always wins; losing an unconsumed one is flagged.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_outValid <= 1'b0;
            r_sumOut   <= '0;
            r_overrun  <= 1'b0;
        end else if (w_frameDone) begin
            r_sumOut   <= w_sum;
            r_outValid <= 1'b1;
            if (r_outValid && !out_ready) begin
                r_overrun <= 1'b1;
            end
        end else if (r_outValid && out_ready) begin
            r_outValid <= 1'b0;
        end
    end

`ifdef MAC_ACC_MAX_EN
    logic [DW-1:0] r_max;
    logic [DW-1:0] r_maxOut;
    logic [DW-1:0] w_maxNext;

    assign w_maxNext = (data_in > r_max) ? data_in : r_max;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_max    <= '0;
            r_maxOut <= '0;
        end else if (w_frameDone) begin
            r_max    <= '0;
            r_maxOut <= w_maxNext;
        end else if (in_valid) begin
            r_max <= w_maxNext;
        end
    end

    assign max_out = r_maxOut;
`else
    assign max_out = '0;
`endif

    assign out_valid  = r_outValid;
    assign sum_out    = r_sumOut;
    assign sample_cnt = r_cnt;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_mac_frame_accumulator.sv
// Self-checking bench for mac_frame_accumulator: directed scenarios plus randomized traffic against a frame-level model.
module tb_mac_frame_accumulator;

    localparam int SIZE      = 8;
    localparam int FRAME_LEN = 4;
    localparam int DW        = 2 * SIZE;
    localparam int CNTW      = $clog2(FRAME_LEN);
    localparam int SUMW      = 2 * SIZE + $clog2(FRAME_LEN);

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            in_valid = 1'b0;
    logic [DW-1:0]   data_in = '0;
    logic            out_ready = 1'b0;
    logic            out_valid;
    logic [SUMW-1:0] sum_out;
    logic [DW-1:0]   max_out;
    logic [CNTW-1:0] sample_cnt;
    logic            overrun;

    int testsRun = 0;
    int testsFailed = 0;

    // Frame-level model: the partial frame is a list of samples, results are computed when it fills.
    int              frameSamples[$];
    logic            expValid = 1'b0;
    logic [SUMW-1:0] expSum = '0;
    logic [DW-1:0]   expMax = '0;
    logic            expOverrun = 1'b0;

    mac_frame_accumulator #(
        .SIZE      (SIZE),
        .FRAME_LEN (FRAME_LEN)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .data_in    (data_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sum_out    (sum_out),
        .max_out    (max_out),
        .sample_cnt (sample_cnt),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // Drives one cycle of inputs, lets the edge happen, advances the model, and settles outputs.
    task automatic applyStimulus(input logic rst, input logic v, input logic [DW-1:0] d, input logic rdy);
        longint total;
        int     biggest;
        reset     = rst;
        in_valid  = v;
        data_in   = d;
        out_ready = rdy;
        @(posedge clk);
        if (rst) begin
            frameSamples.delete();
            expValid   = 1'b0;
            expSum     = '0;
            expMax     = '0;
            expOverrun = 1'b0;
        end else begin
            if (v) frameSamples.push_back(int'(d));
            if (frameSamples.size() == FRAME_LEN) begin
                total   = 0;
                biggest = 0;
                foreach (frameSamples[i]) begin
                    total += frameSamples[i];
                    if (frameSamples[i] > biggest) biggest = frameSamples[i];
                end
                if (expValid && !rdy) expOverrun = 1'b1;
                expValid = 1'b1;
                expSum   = SUMW'(total);
`ifdef MAC_ACC_MAX_EN
                expMax   = DW'(biggest);
`else
                expMax   = '0;
`endif
                frameSamples.delete();
            end else if (expValid && rdy) begin
                expValid = 1'b0;
            end
        end
        #1;
    endtask

    function automatic logic [DW-1:0] maxIfEnabled(input logic [DW-1:0] m);
`ifdef MAC_ACC_MAX_EN
        return m;
`else
        return '0;
`endif
    endfunction

    task automatic test_reset;
        applyStimulus(1'b1, 1'b1, 16'h1234, 1'b1);
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        testsRun += 5;
        if (out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_valid got %0b want 0", out_valid); end
        if (sum_out !== '0) begin testsFailed++; $display("[TB] FAIL reset_sum got %0h want 0", sum_out); end
        if (max_out !== '0) begin testsFailed++; $display("[TB] FAIL reset_max got %0h want 0", max_out); end
        if (sample_cnt !== '0) begin testsFailed++; $display("[TB] FAIL reset_cnt got %0d want 0", sample_cnt); end
        if (overrun !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_overrun got %0b want 0", overrun); end
    endtask

    task automatic test_basic_frame;
        applyStimulus(1'b0, 1'b1, 16'd10, 1'b1);
        testsRun++;
        if (sample_cnt !== CNTW'(1)) begin testsFailed++; $display("[TB] FAIL basic_cnt1 got %0d want 1", sample_cnt); end
        applyStimulus(1'b0, 1'b1, 16'd20, 1'b1);
        applyStimulus(1'b0, 1'b1, 16'd30, 1'b1);
        testsRun++;
        if (out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL basic_early_valid got %0b want 0", out_valid); end
        applyStimulus(1'b0, 1'b1, 16'd40, 1'b1);
        testsRun += 3;
        if (sum_out !== SUMW'(100)) begin testsFailed++; $display("[TB] FAIL basic_sum got %0d want 100", sum_out); end
        if (out_valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL basic_valid got %0b want 1", out_valid); end
        if (max_out !== maxIfEnabled(16'd40)) begin testsFailed++; $display("[TB] FAIL basic_max got %0d want %0d", max_out, maxIfEnabled(16'd40)); end
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        testsRun++;
        if (out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL basic_valid_drop got %0b want 0", out_valid); end
    endtask

    task automatic test_full_scale;
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        for (int i = 0; i < FRAME_LEN; i++) applyStimulus(1'b0, 1'b1, 16'hFFFF, 1'b1);
        testsRun += 2;
        if (sum_out !== 18'h3FFFC) begin testsFailed++; $display("[TB] FAIL full_scale_sum got %0h want 3fffc", sum_out); end
        if (max_out !== maxIfEnabled(16'hFFFF)) begin testsFailed++; $display("[TB] FAIL full_scale_max got %0h want %0h", max_out, maxIfEnabled(16'hFFFF)); end
    endtask

    task automatic test_gaps;
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        applyStimulus(1'b0, 1'b1, 16'd1, 1'b1);
        testsRun++;
        if (sample_cnt !== CNTW'(1)) begin testsFailed++; $display("[TB] FAIL gaps_cnt1 got %0d want 1", sample_cnt); end
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 16'hBEEF, 1'b1);
        testsRun++;
        if (sample_cnt !== CNTW'(1)) begin testsFailed++; $display("[TB] FAIL gaps_hold got %0d want 1", sample_cnt); end
        applyStimulus(1'b0, 1'b1, 16'd2, 1'b1);
        testsRun++;
        if (sample_cnt !== CNTW'(2)) begin testsFailed++; $display("[TB] FAIL gaps_cnt2 got %0d want 2", sample_cnt); end
        applyStimulus(1'b0, 1'b1, 16'd3, 1'b1);
        testsRun++;
        if (sample_cnt !== CNTW'(3)) begin testsFailed++; $display("[TB] FAIL gaps_cnt3 got %0d want 3", sample_cnt); end
        applyStimulus(1'b0, 1'b0, 16'h5555, 1'b1);
        applyStimulus(1'b0, 1'b1, 16'd4, 1'b1);
        testsRun += 3;
        if (sample_cnt !== CNTW'(0)) begin testsFailed++; $display("[TB] FAIL gaps_cnt_wrap got %0d want 0", sample_cnt); end
        if (sum_out !== SUMW'(10)) begin testsFailed++; $display("[TB] FAIL gaps_sum got %0d want 10", sum_out); end
        if (out_valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL gaps_valid got %0b want 1", out_valid); end
    endtask

    task automatic test_overrun;
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < FRAME_LEN; i++) applyStimulus(1'b0, 1'b1, 16'd1, 1'b0);
        testsRun++;
        if (overrun !== 1'b0) begin testsFailed++; $display("[TB] FAIL overrun_first got %0b want 0", overrun); end
        for (int i = 0; i < FRAME_LEN; i++) applyStimulus(1'b0, 1'b1, 16'd2, 1'b0);
        testsRun += 3;
        if (sum_out !== SUMW'(8)) begin testsFailed++; $display("[TB] FAIL overrun_sum got %0d want 8", sum_out); end
        if (out_valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL overrun_valid got %0b want 1", out_valid); end
        if (overrun !== 1'b1) begin testsFailed++; $display("[TB] FAIL overrun_set got %0b want 1", overrun); end
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        testsRun += 2;
        if (out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL overrun_drain got %0b want 0", out_valid); end
        if (overrun !== 1'b1) begin testsFailed++; $display("[TB] FAIL overrun_sticky got %0b want 1", overrun); end
    endtask

    task automatic test_simultaneous;
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < FRAME_LEN; i++) applyStimulus(1'b0, 1'b1, 16'd3, 1'b0);
        for (int i = 0; i < FRAME_LEN - 1; i++) applyStimulus(1'b0, 1'b1, 16'd5, 1'b0);
        testsRun++;
        if (sum_out !== SUMW'(12)) begin testsFailed++; $display("[TB] FAIL simul_hold_sum got %0d want 12", sum_out); end
        applyStimulus(1'b0, 1'b1, 16'd5, 1'b1);
        testsRun += 3;
        if (sum_out !== SUMW'(20)) begin testsFailed++; $display("[TB] FAIL simul_sum got %0d want 20", sum_out); end
        if (out_valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL simul_valid got %0b want 1", out_valid); end
        if (overrun !== 1'b0) begin testsFailed++; $display("[TB] FAIL simul_overrun got %0b want 0", overrun); end
    endtask

    task automatic test_reset_midframe;
        applyStimulus(1'b0, 1'b1, 16'd5, 1'b1);
        applyStimulus(1'b0, 1'b1, 16'd6, 1'b1);
        applyStimulus(1'b1, 1'b1, 16'd9, 1'b1);
        testsRun += 5;
        if (out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL midrst_valid got %0b want 0", out_valid); end
        if (sum_out !== '0) begin testsFailed++; $display("[TB] FAIL midrst_sum got %0d want 0", sum_out); end
        if (max_out !== '0) begin testsFailed++; $display("[TB] FAIL midrst_max got %0d want 0", max_out); end
        if (sample_cnt !== '0) begin testsFailed++; $display("[TB] FAIL midrst_cnt got %0d want 0", sample_cnt); end
        if (overrun !== 1'b0) begin testsFailed++; $display("[TB] FAIL midrst_overrun got %0b want 0", overrun); end
        for (int i = 0; i < FRAME_LEN; i++) applyStimulus(1'b0, 1'b1, 16'd1, 1'b1);
        testsRun += 2;
        if (sum_out !== SUMW'(4)) begin testsFailed++; $display("[TB] FAIL midrst_sum_after got %0d want 4", sum_out); end
        if (out_valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL midrst_valid_after got %0b want 1", out_valid); end
    endtask

    task automatic test_back_to_back;
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        for (int i = 0; i < 2 * FRAME_LEN; i++) begin
            applyStimulus(1'b0, 1'b1, DW'($urandom), 1'b1);
            testsRun += 3;
            if (out_valid !== expValid) begin testsFailed++; $display("[TB] FAIL b2b_valid[%0d] got %0b want %0b", i, out_valid, expValid); end
            if (sum_out !== expSum) begin testsFailed++; $display("[TB] FAIL b2b_sum[%0d] got %0d want %0d", i, sum_out, expSum); end
            if (sample_cnt !== CNTW'((i + 1) % FRAME_LEN)) begin testsFailed++; $display("[TB] FAIL b2b_cnt[%0d] got %0d want %0d", i, sample_cnt, (i + 1) % FRAME_LEN); end
        end
    endtask

    task automatic test_random;
        logic rst;
        logic v;
        logic rdy;
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 79) == 0);
            v   = ($urandom_range(0, 9) < 7);
            rdy = ($urandom_range(0, 3) != 0);
            applyStimulus(rst, v, DW'($urandom), rdy);
            testsRun += 5;
            if (out_valid !== expValid) begin testsFailed++; $display("[TB] FAIL rand_valid[%0d] got %0b want %0b", i, out_valid, expValid); end
            if (sum_out !== expSum) begin testsFailed++; $display("[TB] FAIL rand_sum[%0d] got %0d want %0d", i, sum_out, expSum); end
            if (max_out !== expMax) begin testsFailed++; $display("[TB] FAIL rand_max[%0d] got %0d want %0d", i, max_out, expMax); end
            if (sample_cnt !== CNTW'(frameSamples.size())) begin testsFailed++; $display("[TB] FAIL rand_cnt[%0d] got %0d want %0d", i, sample_cnt, frameSamples.size()); end
            if (overrun !== expOverrun) begin testsFailed++; $display("[TB] FAIL rand_overrun[%0d] got %0b want %0b", i, overrun, expOverrun); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_full_scale();
        test_gaps();
        test_overrun();
        test_simultaneous();
        test_reset_midframe();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
